alu_slice_sequencer: RTL and testbench
======================================

# alu_slice_sequencer

Multi-cycle controller that performs one W-bit ALU operation by issuing it to a single external 4-bit 74181-style ALU slice, one nibble per cycle, least-significant first. It chains the slice's active-low carry between nibbles, assembles the result, and derives carry and zero flags. It sits between an operand producer (valid/ready) and the shared 4-bit ALU slice, replacing a wide ripple of slices with one slice time-multiplexed over NIBBLES cycles.

## Interface
- NIBBLES, 4, number of nibble passes per operation; W = 4*NIBBLES, minimum 1.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_a, in_b  in  W  operands.
- in_s  in  4  74181 function select.
- in_m  in  1  mode: 1 = logic, 0 = arithmetic.
- in_cin_n  in  1  active-low carry into nibble 0.
- alu_a, alu_b  out  4  nibble presented to the slice.
- alu_s  out  4  function select to the slice.
- alu_m  out  1  mode to the slice.
- alu_cn_n  out  1  active-low carry-in to the slice.
- alu_f  in  4  slice result.
- alu_cn4_n  in  1  slice active-low carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_f  out  W  assembled result.
- out_cout_n  out  1  active-low carry-out of the top nibble.
- out_zero  out  1  high when out_f == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when in_valid && in_ready.
  - Latch in_a, in_b, in_s, in_m, in_cin_n.
  - Set idx = 0; carry register = in_cin_n.
- RUN, each cycle:
  - Drive alu_a = a[4*idx+:4], alu_b = b[4*idx+:4], alu_s/alu_m from the latched request, alu_cn_n = carry register.
  - Capture alu_f into f[4*idx+:4] and alu_cn4_n into the carry register.
  - idx increments; wraps to 0.
  - When idx == NIBBLES-1, go to DONE.
- DONE:
  - out_valid = 1.
  - out_f, out_cout_n (last carry register) and out_zero (registered, computed from the final f) are held stable.
  - Go to IDLE on out_ready.
- Carry is chained in logic mode too. out_cout_n is then the slice's output, not meaningful; the block does not suppress it.
- in_ready = (state == IDLE). in_valid outside IDLE is ignored.
- Outside RUN, the slice sees: alu_a = alu_b = 0, alu_s = 0, alu_m = 1, alu_cn_n = 1.
- Input data changes while not in IDLE are ignored; the latched copies are used.

## Timing
- Reset (rst_n low at an edge):
  - state = IDLE, idx = 0.
  - out_valid = 0, out_f = 0, out_cout_n = 1, out_zero = 0, carry register = 1.
  - in_ready = 1 from the first cycle after reset.
- Latency: accept edge T; RUN during cycles T+1 … T+NIBBLES; out_valid high from cycle T+NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles with out_ready held high. No overlap of accept and DONE.
- The slice is combinational. alu_f and alu_cn4_n are sampled at the end of the same cycle that drives the nibble.
- Backpressure: DONE is held indefinitely while out_ready = 0; outputs do not change.
- Reset mid-RUN or mid-DONE: the operation is abandoned, the reset values above apply at that edge, and no partial result is ever flagged valid.
- NIBBLES = 1: RUN lasts exactly one cycle.

## Structure
- The shared package/header holds:
  - state encodings (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - the 74181 select constants used by the bench (ADD = 4'b1001, SUB = 4'b0110 with M = 0, XOR = 4'b0110 with M = 1).
- One sub-module, alu_nibble_sel: a combinational nibble extractor/inserter indexed by idx, reused for both operand muxing and result assembly.
- FSM, idx counter, carry register and flags stay in the top.

## Test plan
- ADD, cin_n = 1: 0x1234 + 0x0FFF → out_f = 0x2233, out_cout_n = 1, out_zero = 0, out_valid exactly 5 cycles after accept.
- ADD, cin_n = 1: 0xFFFF + 0x0001 → 0x0000, out_cout_n = 0, out_zero = 1. This checks carry ripple through all 4 nibbles.
- SUB, cin_n = 0: 0x5000 − 0x0001 → 0x4FFF, out_cout_n = 0 (no borrow).
- XOR: 0xAAAA ^ 0xFFFF → 0x5555. alu_m = 1 during all RUN cycles.
- Backpressure and ignored request:
  - hold out_ready = 0 for 3 cycles in DONE → out_f/flags stable and in_ready = 0 throughout;
  - a second in_valid during this window is not accepted until after out_ready.
- Mid-operation reset: assert rst_n = 0 at RUN idx = 2 → next cycle state IDLE, out_valid = 0, out_f = 0, in_ready = 1, alu_cn_n = 1.

Source files
------------

// File: rtl/alu_slice_sequencer_pkg.sv
// Shared definitions for the nibble-serial 74181 sequencer: FSM encodings,
// slice function selects, and the layout of the per-nibble operand lane.
package alu_slice_sequencer_pkg;

  // FSM encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // 74181 function selects (ADD/SUB with M = 0, XOR with M = 1)
  localparam logic [3:0] SEL_ADD = 4'b1001;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_XOR = 4'b0110;

  // Each nibble position keeps {b nibble, a nibble}. The a half is
  // overwritten in place by the slice result once that nibble retires.
  localparam int LANE_W = 8;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
  } op_ctrl_t;

  // Function/mode the slice sees whenever no operation is in flight.
  localparam op_ctrl_t IDLE_CTRL = '{s: 4'b0000, m: 1'b1};

  function automatic logic [LANE_W-1:0] make_lane(input logic [3:0] b_nib,
                                                 input logic [3:0] a_nib);
    return {b_nib, a_nib};
  endfunction

endpackage

// File: rtl/alu_nibble_sel.sv
// Combinational lane extractor/inserter: returns the lane selected by idx_i
// and a copy of the word with that lane replaced by lane_i. An idx_i beyond
// the last lane extracts zero and leaves the word untouched.
module alu_nibble_sel
  import alu_slice_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int LANE_W  = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NIBBLES*LANE_W-1:0] word_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic [LANE_W-1:0]         lane_i,
  output logic [LANE_W-1:0]         lane_o,
  output logic [NIBBLES*LANE_W-1:0] word_o
);

  logic [NIBBLES-1:0] hit;
  logic [LANE_W-1:0]  masked [NIBBLES];

  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_lane
      assign hit[gi]    = (idx_i == IDX_W'(gi));
      assign masked[gi] = hit[gi] ? word_i[gi*LANE_W +: LANE_W] : '0;
      assign word_o[gi*LANE_W +: LANE_W] =
        hit[gi] ? lane_i : word_i[gi*LANE_W +: LANE_W];
    end
  endgenerate

  // OR-reduce the one-hot masked lanes into the extracted lane
  always_comb begin
    lane_o = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      lane_o = lane_o | masked[i];
    end
  end

endmodule

// File: rtl/alu_slice_sequencer.sv
// Runs one W-bit ALU operation through a single external 4-bit 74181 slice,
// one nibble per cycle, LSB first, chaining the active-low carry between
// passes and presenting the assembled result with carry and zero flags.
module alu_slice_sequencer
  import alu_slice_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // request side
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic [3:0]           in_s,
  input  logic                 in_m,
  input  logic                 in_cin_n,
  // slice side
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [3:0]           alu_s,
  output logic                 alu_m,
  output logic                 alu_cn_n,
  input  logic [3:0]           alu_f,
  input  logic                 alu_cn4_n,
  // result side
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_f,
  output logic                 out_cout_n,
  output logic                 out_zero
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [1:0]                state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NIBBLES*LANE_W-1:0] lanes_q, lanes_d;
  op_ctrl_t                  ctrl_q, ctrl_d;
  logic                      carry_q, carry_d;
  logic                      zero_q, zero_d;

  logic [NIBBLES*LANE_W-1:0] load_lanes;
  logic [NIBBLES*LANE_W-1:0] lanes_ins;
  logic [LANE_W-1:0]         cur_lane;
  logic [LANE_W-1:0]         new_lane;
  logic [W-1:0]              f_now;
  logic [W-1:0]              f_next;
  logic                      run;

  // Interleave operands into lanes on accept; result bits are the low half
  // of every lane, both as stored and as they will be after this pass.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_lane
      assign load_lanes[gi*LANE_W +: LANE_W] =
        make_lane(in_b[4*gi +: 4], in_a[4*gi +: 4]);
      assign f_now[4*gi +: 4]  = lanes_q[gi*LANE_W +: 4];
      assign f_next[4*gi +: 4] = lanes_ins[gi*LANE_W +: 4];
    end
  endgenerate

  // One selector both feeds the current operand nibbles to the slice and
  // writes the slice result back over the consumed a nibble.
  alu_nibble_sel #(
    .NIBBLES (NIBBLES),
    .LANE_W  (LANE_W),
    .IDX_W   (IDX_W)
  ) u_nibble_sel (
    .word_i (lanes_q),
    .idx_i  (idx_q),
    .lane_i (new_lane),
    .lane_o (cur_lane),
    .word_o (lanes_ins)
  );

  assign new_lane = {cur_lane[LANE_W-1:4], alu_f};

  assign run        = (state_q == ST_RUN);
  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_f      = f_now;
  assign out_cout_n = carry_q;
  assign out_zero   = zero_q;

  // Slice drive: live nibble while running, a quiet logic-mode pattern otherwise
  always_comb begin
    alu_a    = 4'h0;
    alu_b    = 4'h0;
    alu_s    = IDLE_CTRL.s;
    alu_m    = IDLE_CTRL.m;
    alu_cn_n = 1'b1;
    if (run) begin
      alu_a    = cur_lane[3:0];
      alu_b    = cur_lane[7:4];
      alu_s    = ctrl_q.s;
      alu_m    = ctrl_q.m;
      alu_cn_n = carry_q;
    end
  end

  // Next-state: accept in IDLE, one nibble per RUN cycle, hold DONE until taken
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    ctrl_d  = ctrl_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          idx_d   = '0;
          lanes_d = load_lanes;
          ctrl_d  = '{s: in_s, m: in_m};
          carry_d = in_cin_n;
        end
      end
      ST_RUN: begin
        lanes_d = lanes_ins;
        carry_d = alu_cn4_n;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
          zero_d  = (f_next == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lanes_q <= '0;
      ctrl_q  <= IDLE_CTRL;
      carry_q <= 1'b1;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      ctrl_q  <= ctrl_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Directed bench: a behavioural 74181 slice is attached to the sequencer and
// a table of hand-computed operations is run, plus backpressure and reset
// sequences. Inputs change on the falling edge; outputs are sampled there too.
module tb_alu_slice_sequencer;
  import alu_slice_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_s;
  logic        in_m, in_cin_n;
  logic [3:0]  alu_a, alu_b, alu_s, alu_f;
  logic        alu_m, alu_cn_n, alu_cn4_n;
  logic        out_valid, out_ready;
  logic [15:0] out_f;
  logic        out_cout_n, out_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_slice_sequencer #(.NIBBLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_s       (in_s),
    .in_m       (in_m),
    .in_cin_n   (in_cin_n),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_m      (alu_m),
    .alu_cn_n   (alu_cn_n),
    .alu_f      (alu_f),
    .alu_cn4_n  (alu_cn4_n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .out_cout_n (out_cout_n),
    .out_zero   (out_zero)
  );

  // Behavioural slice covering the functions this bench uses; returns {cn4_n, f}
  function automatic logic [4:0] slice(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] s, input logic m,
                                       input logic cn_n);
    logic [4:0] sum;
    if (m) begin
      case (s)
        4'b0110: sum = {1'b0, a ^ b};
        4'b1011: sum = {1'b0, a & b};
        4'b1110: sum = {1'b0, a | b};
        default: sum = {1'b0, ~a};
      endcase
      return {1'b1, sum[3:0]};
    end
    case (s)
      4'b1001: sum = {1'b0, a} + {1'b0, b} + {4'b0, ~cn_n};
      4'b0110: sum = {1'b0, a} + {1'b0, ~b} + {4'b0, ~cn_n};
      default: sum = {1'b0, a} + {4'b0, ~cn_n};
    endcase
    return {~sum[4], sum[3:0]};
  endfunction

  always_comb {alu_cn4_n, alu_f} = slice(alu_a, alu_b, alu_s, alu_m, alu_cn_n);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cin_n;
    logic [15:0] exp_f;
    logic        chk_cout;
    logic        exp_cout_n;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [9];

  // Drive one vector from IDLE through DONE and back to IDLE (6 falling edges)
  task automatic run_vec(input vec_t v);
    logic [15:0] a;
    logic [15:0] b;
    logic        cn;
    logic [4:0]  r;
    a  = v.a;
    b  = v.b;
    cn = v.cin_n;
    chk({v.name, "/in_ready_idle"}, 32'(in_ready), 32'(1));
    in_valid = 1'b1; in_a = a; in_b = b; in_s = v.s; in_m = v.m; in_cin_n = v.cin_n;
    @(negedge clk);
    // scramble inputs: the latched copies must be used
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_s = ~v.s; in_m = ~v.m; in_cin_n = ~v.cin_n;
    for (int k = 0; k < 4; k++) begin
      chk({v.name, "/run_valid"}, 32'(out_valid), 32'(0));
      chk({v.name, "/run_ready"}, 32'(in_ready), 32'(0));
      chk({v.name, "/alu_a"}, 32'(alu_a), 32'(a[4*k +: 4]));
      chk({v.name, "/alu_b"}, 32'(alu_b), 32'(b[4*k +: 4]));
      chk({v.name, "/alu_s"}, 32'(alu_s), 32'(v.s));
      chk({v.name, "/alu_m"}, 32'(alu_m), 32'(v.m));
      chk({v.name, "/alu_cn_n"}, 32'(alu_cn_n), 32'(cn));
      r  = slice(a[4*k +: 4], b[4*k +: 4], v.s, v.m, cn);
      cn = r[4];
      @(negedge clk);
    end
    chk({v.name, "/done_valid"}, 32'(out_valid), 32'(1));
    chk({v.name, "/done_ready"}, 32'(in_ready), 32'(0));
    chk({v.name, "/out_f"}, 32'(out_f), 32'(v.exp_f));
    chk({v.name, "/out_zero"}, 32'(out_zero), 32'(v.exp_zero));
    if (v.chk_cout) chk({v.name, "/out_cout_n"}, 32'(out_cout_n), 32'(v.exp_cout_n));
    $display("op %-10s a=%h b=%h s=%b m=%b cin_n=%b -> f=%h cout_n=%b zero=%b",
             v.name, v.a, v.b, v.s, v.m, v.cin_n, out_f, out_cout_n, out_zero);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({v.name, "/idle_valid"}, 32'(out_valid), 32'(0));
    chk({v.name, "/idle_ready"}, 32'(in_ready), 32'(1));
    chk({v.name, "/idle_alu_m"}, 32'(alu_m), 32'(1));
    chk({v.name, "/idle_alu_cn"}, 32'(alu_cn_n), 32'(1));
    chk({v.name, "/idle_alu_a"}, 32'(alu_a), 32'(0));
    chk({v.name, "/idle_alu_s"}, 32'(alu_s), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"add",       16'h1234, 16'h0FFF, SEL_ADD, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{"add_wrap",  16'hFFFF, 16'h0001, SEL_ADD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"sub",       16'h5000, 16'h0001, SEL_SUB, 1'b0, 1'b0, 16'h4FFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"xor",       16'hAAAA, 16'hFFFF, SEL_XOR, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"add_cin",   16'h0000, 16'h0000, SEL_ADD, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{"sub_eq",    16'h1234, 16'h1234, SEL_SUB, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{"sub_borrow",16'h0001, 16'h0002, SEL_SUB, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{"xor_zero",  16'h5A5A, 16'h5A5A, SEL_XOR, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{"add_mid",   16'h00F0, 16'h0010, SEL_ADD, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_s = '0; in_m = 1'b0;
    in_cin_n = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    chk("rst/in_ready", 32'(in_ready), 32'(1));
    chk("rst/out_valid", 32'(out_valid), 32'(0));
    chk("rst/out_f", 32'(out_f), 32'(0));
    chk("rst/out_cout_n", 32'(out_cout_n), 32'(1));
    chk("rst/out_zero", 32'(out_zero), 32'(0));
    chk("rst/alu_m", 32'(alu_m), 32'(1));
    chk("rst/alu_cn_n", 32'(alu_cn_n), 32'(1));
    chk("rst/alu_a", 32'(alu_a), 32'(0));
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Backpressure: DONE held 3 cycles with a competing request pending
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0FFF; in_s = SEL_ADD; in_m = 1'b0; in_cin_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_s = SEL_ADD; in_m = 1'b0; in_cin_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("bp/out_valid", 32'(out_valid), 32'(1));
      chk("bp/in_ready", 32'(in_ready), 32'(0));
      chk("bp/out_f", 32'(out_f), 32'h2233);
      chk("bp/out_cout_n", 32'(out_cout_n), 32'(1));
      chk("bp/out_zero", 32'(out_zero), 32'(0));
      @(negedge clk);
    end
    $display("op backpress f=%h held for 3 cycles", out_f);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp/idle_ready", 32'(in_ready), 32'(1));
    chk("bp/idle_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp2/accepted", 32'(in_ready), 32'(0));
    repeat (4) @(negedge clk);
    chk("bp2/out_valid", 32'(out_valid), 32'(1));
    chk("bp2/out_f", 32'(out_f), 32'h0000);
    chk("bp2/out_cout_n", 32'(out_cout_n), 32'(0));
    chk("bp2/out_zero", 32'(out_zero), 32'(1));
    $display("op bp_second f=%h cout_n=%b zero=%b", out_f, out_cout_n, out_zero);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset at RUN idx = 2 abandons the operation
    in_valid = 1'b1; in_a = 16'h4321; in_b = 16'h1111; in_s = SEL_ADD; in_m = 1'b0; in_cin_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst/alu_a_idx2", 32'(alu_a), 32'(3));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst/out_valid", 32'(out_valid), 32'(0));
    chk("mrst/out_f", 32'(out_f), 32'(0));
    chk("mrst/in_ready", 32'(in_ready), 32'(1));
    chk("mrst/alu_cn_n", 32'(alu_cn_n), 32'(1));
    chk("mrst/out_cout_n", 32'(out_cout_n), 32'(1));
    chk("mrst/out_zero", 32'(out_zero), 32'(0));
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("mrst/no_valid", 32'(out_valid), 32'(0));
      @(negedge clk);
    end
    $display("op mid_reset abandoned, idle afterwards");

    // Recovery after mid-operation reset
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
